// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS-subset control unit.
// Used by the FSM top, its ULA decoder and the control interface.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH   = 4'h0,
        S_FETCH2  = 4'h1,
        S_DECODE  = 4'h2,
        S_EXEC_R  = 4'h3,
        S_EXEC_I  = 4'h4,
        S_ALU_WB  = 4'h5,
        S_MEMADR  = 4'h6,
        S_MEM_RD  = 4'h7,
        S_MEM_WB  = 4'h8,
        S_MEM_WR  = 4'h9,
        S_BRANCH  = 4'hA,
        S_JUMP    = 4'hB,
        S_ILLEGAL = 4'hC,
        S_HALT    = 4'hF
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD   = 2'd0,
        CLS_SUB   = 2'd1,
        CLS_FUNCT = 2'd2
    } ula_cls_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_SLT = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_BR  = 2'b01;
    localparam logic [1:0] PC_JMP = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle FSM (master) and the datapath (slave).
// Carries instruction fields and flags in, datapath enables/selects out.
interface multicycle_ctrl_fsm_if;
    import mips_ctrl_pkg::*;

    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       ula_src;
    logic [2:0] ula_control;
    logic       mem_write;
    logic       mem_to_reg;

    modport master (
        input  op, funct, zero,
        output pc_write, pc_src, ir_write, reg_write, reg_dst,
        output ula_src, ula_control, mem_write, mem_to_reg
    );

    modport slave (
        output op, funct, zero,
        input  pc_write, pc_src, ir_write, reg_write, reg_dst,
        input  ula_src, ula_control, mem_write, mem_to_reg
    );

endinterface

// File: rtl/ula_op_decode.sv
// Maps an operation class (add / sub / R-type funct) to a ULA control code.
// valid drops for an unknown funct so the FSM can divert to ILLEGAL.
module ula_op_decode
    import mips_ctrl_pkg::*;
#(
    parameter logic [2:0] ADD_CODE = ULA_ADD,
    parameter logic [2:0] SUB_CODE = ULA_SUB
) (
    input  ula_cls_t   cls,
    input  logic [5:0] funct,
    output logic [2:0] ula_control,
    output logic       valid
);

    always_comb begin
        ula_control = ADD_CODE;
        valid       = 1'b1;
        unique case (cls)
            CLS_ADD: ula_control = ADD_CODE;
            CLS_SUB: ula_control = SUB_CODE;
            CLS_FUNCT: begin
                case (funct)
                    FN_ADD:  ula_control = ADD_CODE;
                    FN_SUB:  ula_control = SUB_CODE;
                    FN_AND:  ula_control = ULA_AND;
                    FN_OR:   ula_control = ULA_OR;
                    FN_SLT:  ula_control = ULA_SLT;
                    default: valid = 1'b0;
                endcase
            end
            default: ula_control = ADD_CODE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle control FSM for the 8-bit MIPS-subset datapath.
// Build option HALT_ON_ILLEGAL_EN: ILLEGAL parks in HALT until reset.
module multicycle_ctrl_fsm
    import mips_ctrl_pkg::*;
#(
    parameter int         CNT_W    = 8,
    parameter logic [2:0] ADD_CODE = 3'b010,
    parameter logic [2:0] SUB_CODE = 3'b110
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  step_en,
    multicycle_ctrl_fsm_if.master bus,
    output logic [3:0]            state_o,
    output logic                  illegal,
    output logic [CNT_W-1:0]      retired
);

    state_t     state_q;
    state_t     state_d;
    ula_cls_t   cls;
    logic [2:0] ula_code;
    logic       fn_ok;
    logic       is_r;

    logic       pc_wr;
    logic [1:0] pc_sel;
    logic       ir_wr;
    logic       reg_wr;
    logic       rdst;
    logic       usrc;
    logic       mem_wr;
    logic       m2r;

    assign is_r = (bus.op == OP_RTYPE);

    always_comb begin
        cls = CLS_ADD;
        if (state_q == S_BRANCH)
            cls = CLS_SUB;
        else if (is_r && (state_q == S_EXEC_R || state_q == S_ALU_WB))
            cls = CLS_FUNCT;
    end

    ula_op_decode #(
        .ADD_CODE (ADD_CODE),
        .SUB_CODE (SUB_CODE)
    ) u_ula_dec (
        .cls         (cls),
        .funct       (bus.funct),
        .ula_control (ula_code),
        .valid       (fn_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= S_FETCH;
        else if (step_en)
            state_q <= state_d;
    end

    always_comb begin
        state_d = S_FETCH;
        unique case (state_q)
            S_FETCH:  state_d = S_FETCH2;
            S_FETCH2: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_RTYPE:      state_d = S_EXEC_R;
                    OP_ADDI:       state_d = S_EXEC_I;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    default:       state_d = S_ILLEGAL;
                endcase
            end
            S_EXEC_R: state_d = fn_ok ? S_ALU_WB : S_ILLEGAL;
            S_EXEC_I: state_d = S_ALU_WB;
            S_MEMADR: state_d = (bus.op == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD: state_d = S_MEM_WB;
`ifdef HALT_ON_ILLEGAL_EN
            S_ILLEGAL: state_d = S_HALT;
            S_HALT:    state_d = S_HALT;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    // Selects stay up through each write-back state so the write edge sees
    // settled datapath values; enables are gated by step_en below.
    always_comb begin
        pc_wr  = 1'b0;
        pc_sel = PC_SEQ;
        ir_wr  = 1'b0;
        reg_wr = 1'b0;
        rdst   = 1'b0;
        usrc   = 1'b0;
        mem_wr = 1'b0;
        m2r    = 1'b0;
        unique case (state_q)
            S_FETCH2: ir_wr = 1'b1;
            S_EXEC_R: rdst = is_r;
            S_EXEC_I: usrc = 1'b1;
            S_ALU_WB: begin
                reg_wr = 1'b1;
                rdst   = is_r;
                usrc   = !is_r;
                pc_wr  = 1'b1;
            end
            S_MEMADR: usrc = 1'b1;
            S_MEM_RD: begin
                usrc = 1'b1;
                m2r  = 1'b1;
            end
            S_MEM_WB: begin
                usrc   = 1'b1;
                m2r    = 1'b1;
                reg_wr = 1'b1;
                pc_wr  = 1'b1;
            end
            S_MEM_WR: begin
                usrc   = 1'b1;
                mem_wr = 1'b1;
                pc_wr  = 1'b1;
            end
            S_BRANCH: begin
                pc_wr  = 1'b1;
                pc_sel = bus.zero ? PC_BR : PC_SEQ;
            end
            S_JUMP: begin
                pc_wr  = 1'b1;
                pc_sel = PC_JMP;
            end
            S_ILLEGAL: pc_wr = 1'b1;
            default: ;
        endcase
    end

    assign bus.pc_write    = pc_wr & step_en;
    assign bus.pc_src      = pc_sel;
    assign bus.ir_write    = ir_wr & step_en;
    assign bus.reg_write   = reg_wr & step_en;
    assign bus.reg_dst     = rdst;
    assign bus.ula_src     = usrc;
    assign bus.ula_control = ula_code;
    assign bus.mem_write   = mem_wr & step_en;
    assign bus.mem_to_reg  = m2r;

    assign state_o = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
            retired <= '0;
        end else begin
            if (step_en && state_q == S_ILLEGAL)
                illegal <= 1'b1;
            if (pc_wr && step_en)
                retired <= retired + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: instruction table plus a retire scoreboard.
// Hand sequences cover stall, async reset, counter wrap and illegal opcodes.
module tb_multicycle_ctrl_fsm;

    typedef struct {
        logic [47:0] name;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        int          steps;
        logic [1:0]  pc_src;
        logic        rw;
        logic        mw;
        logic        m2r;
        logic        rdst;
        logic        chk_alu;
        logic        usrc;
        logic [2:0]  ula;
        logic        ill;
        logic [3:0]  end_st;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step_en;
    logic [3:0] state_o;
    logic       illegal;
    logic [7:0] retired;

    multicycle_ctrl_fsm_if bus ();

    multicycle_ctrl_fsm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .bus     (bus.master),
        .state_o (state_o),
        .illegal (illegal),
        .retired (retired)
    );

    always #5 clk = ~clk;

    int   cmp  = 0;
    int   mism = 0;
    int   steps = 0;
    logic [7:0] exp_retired = 8'd0;
    vec_t sb[$];
    vec_t vecs[10];
    vec_t mv;
    vec_t vj;

    task automatic chk(input string what, input int act, input int exp);
        cmp++;
        if (act != exp) begin
            mism++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", what, act, exp, $time);
        end
    endtask

    // Scoreboard: every retiring step pops one expected instruction.
    always @(negedge clk) begin
        if (!rst_n) begin
            steps = 0;
        end else if (step_en) begin
            steps++;
            chk("stray_write",
                int'((bus.reg_write || bus.mem_write) && !bus.pc_write), 0);
            if (bus.pc_write) begin
                if (sb.size() == 0) begin
                    chk("unexpected_retire", 1, 0);
                end else begin
                    mv = sb.pop_front();
                    chk($sformatf("%0s/steps", mv.name), steps, mv.steps);
                    chk($sformatf("%0s/pc_src", mv.name), bus.pc_src, mv.pc_src);
                    chk($sformatf("%0s/reg_write", mv.name), bus.reg_write, mv.rw);
                    chk($sformatf("%0s/mem_write", mv.name), bus.mem_write, mv.mw);
                    if (mv.rw) begin
                        chk($sformatf("%0s/mem_to_reg", mv.name), bus.mem_to_reg, mv.m2r);
                        chk($sformatf("%0s/reg_dst", mv.name), bus.reg_dst, mv.rdst);
                    end
                    if (mv.chk_alu) begin
                        chk($sformatf("%0s/ula_ctl", mv.name), bus.ula_control, mv.ula);
                        chk($sformatf("%0s/ula_src", mv.name), bus.ula_src, mv.usrc);
                    end
                end
                exp_retired = exp_retired + 8'd1;
                steps = 0;
            end
        end
    end

    task automatic issue(input vec_t v);
        bus.op    = v.op;
        bus.funct = v.funct;
        bus.zero  = v.zero;
        sb.push_back(v);
        step_en   = 1'b1;
    endtask

    task automatic drain(input vec_t v);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sb.size() == 0) break;
        end
        if (sb.size() != 0) begin
            chk($sformatf("%0s/timeout", v.name), 1, 0);
            sb.delete();
        end
        chk($sformatf("%0s/retired", v.name), retired, exp_retired);
        chk($sformatf("%0s/illegal", v.name), illegal, v.ill);
        chk($sformatf("%0s/end_state", v.name), state_o, v.end_st);
    endtask

    task automatic wait_state(input logic [3:0] s, input string what);
        for (int i = 0; i < 20; i++) begin
            if (state_o == s) break;
            @(posedge clk);
            #1;
        end
        chk(what, state_o, s);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb.delete();
        exp_retired = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"add",  6'h00, 6'h20, 1'b0, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b010, 1'b0, 4'h0};
        vecs[1] = '{"sub",  6'h00, 6'h22, 1'b0, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b110, 1'b0, 4'h0};
        vecs[2] = '{"and",  6'h00, 6'h24, 1'b1, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b000, 1'b0, 4'h0};
        vecs[3] = '{"or",   6'h00, 6'h25, 1'b0, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b001, 1'b0, 4'h0};
        vecs[4] = '{"slt",  6'h00, 6'h2A, 1'b0, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3'b111, 1'b0, 4'h0};
        vecs[5] = '{"addi", 6'h08, 6'h3F, 1'b0, 5, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 4'h0};
        vecs[6] = '{"lw",   6'h23, 6'h00, 1'b0, 6, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 4'h0};
        vecs[7] = '{"sw",   6'h2B, 6'h00, 1'b0, 5, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010, 1'b0, 4'h0};
        vecs[8] = '{"beq_t", 6'h04, 6'h00, 1'b1, 4, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 4'h0};
        vecs[9] = '{"beq_n", 6'h04, 6'h00, 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 1'b0, 4'h0};
        vj      = '{"j",    6'h02, 6'h00, 1'b0, 4, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 4'h0};

        rst_n     = 1'b0;
        step_en   = 1'b0;
        bus.op    = 6'h00;
        bus.funct = 6'h20;
        bus.zero  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst/state", state_o, 0);
        chk("rst/enables",
            {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, 0);
        chk("rst/pc_src", bus.pc_src, 0);
        chk("rst/ula_ctl", bus.ula_control, 3'b010);
        chk("rst/illegal", illegal, 0);
        chk("rst/retired", retired, 0);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i]);
            drain(vecs[i]);
        end
        issue(vj);
        drain(vj);

        // lw stalled in MEM_RD for 10 clocks
        issue(vecs[6]);
        wait_state(4'h7, "stall/reach_mem_rd");
        step_en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("stall/frozen",
                {state_o, bus.pc_write, bus.ir_write, bus.reg_write,
                 bus.mem_write, bus.mem_to_reg, bus.ula_src, bus.ula_control},
                {4'h7, 4'b0000, 1'b1, 1'b1, 3'b010});
        end
        @(posedge clk);
        #1;
        step_en = 1'b1;
        drain(vecs[6]);

        // async reset between edges while ALU_WB is writing
        issue(vecs[0]);
        wait_state(4'h5, "areset/reach_alu_wb");
        chk("areset/reg_write_before", bus.reg_write, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset/reg_write_after", bus.reg_write, 0);
        chk("areset/state", state_o, 0);
        chk("areset/retired", retired, 0);
        sb.delete();
        exp_retired = 8'd0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 300; i++) begin
            issue(vj);
            drain(vj);
        end
        chk("wrap/retired_300", retired, 44);

`ifdef HALT_ON_ILLEGAL_EN
        begin
            vec_t vh;
            vh = '{"illop", 6'h3F, 6'h00, 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 4'hF};
            issue(vh);
            drain(vh);
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                chk("halt/state", state_o, 4'hF);
                chk("halt/enables",
                    {bus.pc_write, bus.ir_write, bus.reg_write, bus.mem_write}, 0);
                chk("halt/retired", retired, exp_retired);
            end
            #2;
            rst_n = 1'b0;
            #1;
            chk("halt/reset_state", state_o, 0);
            chk("halt/reset_illegal", illegal, 0);
            do_reset();
        end
`else
        begin
            vec_t vi;
            vec_t vf;
            vi = '{"illop", 6'h3F, 6'h00, 1'b0, 4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 4'h0};
            vf = '{"illfn", 6'h00, 6'h07, 1'b0, 5, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 4'h0};
            issue(vi);
            drain(vi);
            issue(vf);
            drain(vf);
            issue(vecs[5]);
            vecs[5].ill = 1'b1;
            sb[0].ill = 1'b1;
            drain(vecs[5]);
        end
`endif

        step_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mism);
        $finish;
    end

endmodule
